// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// the bundle of pipeline-register controls with its idle (no-stall) value.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_bubble;
    logic memwb_bubble;
    logic mul_start;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    ifid_flush:   1'b0,
    idex_write:   1'b1,
    idex_bubble:  1'b0,
    exmem_write:  1'b1,
    exmem_bubble: 1'b0,
    memwb_bubble: 1'b0,
    mul_start:    1'b0
  };

  // MUL occupancy: front of the pipe holds, EX/MEM gets a NOP while EX is busy.
  function automatic ctrl_t mul_stall_ctrl(input logic start);
    ctrl_t c;
    c              = CTRL_DEFAULT;
    c.pc_write     = 1'b0;
    c.ifid_write   = 1'b0;
    c.idex_write   = 1'b0;
    c.exmem_bubble = 1'b1;
    c.mul_start    = start;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard flags into the stall sequencer and the pipeline-register controls out of it.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             load_use_i;
  logic             branch_taken_i;
  logic             ex_mul_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             stat_clr_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             exmem_bubble_o;
  logic             memwb_bubble_o;
  logic             mul_start_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             mem_timeout_o;

  modport master (
    output load_use_i, branch_taken_i, ex_mul_i, mem_req_i, mem_ack_i, stat_clr_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
           exmem_write_o, exmem_bubble_o, memwb_bubble_o, mul_start_o,
           stall_cnt_o, mem_timeout_o
  );

  modport slave (
    input  load_use_i, branch_taken_i, ex_mul_i, mem_req_i, mem_ack_i, stat_clr_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
           exmem_write_o, exmem_bubble_o, memwb_bubble_o, mul_start_o,
           stall_cnt_o, mem_timeout_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges D-cache freeze,
// multi-cycle MUL, load-use and taken-branch into one set of register controls.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int MC_W  = $clog2(MUL_LAT);
  localparam int FRZ_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic [FRZ_W-1:0]  frz_cnt;
  logic              freeze;
  logic              timeout_q;
  ctrl_t             ctrl;

  // An ack without a request is not a completed access.
  assign freeze = bus.mem_req_i & ~bus.mem_ack_i;

  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    if (!rst_i) begin
      if (freeze) begin
        ctrl.pc_write     = 1'b0;
        ctrl.ifid_write   = 1'b0;
        ctrl.idex_write   = 1'b0;
        ctrl.exmem_write  = 1'b0;
        ctrl.memwb_bubble = 1'b1;
      end else if (state_q == MUL_BUSY) begin
        if (mul_cnt_q > MC_W'(1)) begin
          ctrl      = mul_stall_ctrl(1'b0);
          mul_cnt_d = mul_cnt_q - 1'b1;
        end else begin
          mul_cnt_d = '0;
          state_d   = RUN;
        end
      end else if (bus.ex_mul_i) begin
        ctrl      = mul_stall_ctrl(1'b1);
        mul_cnt_d = MC_W'(MUL_LAT - 1);
        state_d   = MUL_BUSY;
      end else if (bus.load_use_i) begin
        ctrl.pc_write    = 1'b0;
        ctrl.ifid_write  = 1'b0;
        ctrl.idex_bubble = 1'b1;
      end else if (bus.branch_taken_i) begin
        ctrl.ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (bus.stat_clr_i),
    .inc (~ctrl.pc_write),
    .cnt (bus.stall_cnt_o)
  );

  sat_counter #(.WIDTH(FRZ_W)) u_frz_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (~freeze),
    .inc (freeze),
    .cnt (frz_cnt)
  );

  // Sticky: set on the edge that completes the MEM_TIMEOUT-th consecutive freeze cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else if (freeze && (frz_cnt >= FRZ_W'(MEM_TIMEOUT - 1))) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.ifid_write_o   = ctrl.ifid_write;
  assign bus.ifid_flush_o   = ctrl.ifid_flush;
  assign bus.idex_write_o   = ctrl.idex_write;
  assign bus.idex_bubble_o  = ctrl.idex_bubble;
  assign bus.exmem_write_o  = ctrl.exmem_write;
  assign bus.exmem_bubble_o = ctrl.exmem_bubble;
  assign bus.memwb_bubble_o = ctrl.memwb_bubble;
  assign bus.mul_start_o    = ctrl.mul_start;
  assign bus.mem_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a rule-level model of the stall priorities.
module tb_pipeline_stall_ctrl;

  localparam int MUL_LAT     = 4;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic rst_i;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Current stimulus and model state.
  logic i_lu, i_br, i_mul, i_req, i_ack, i_clr, i_rst;
  int   m_mul_left;
  int   m_stall;
  int   m_frz;
  logic m_tmo;

  task automatic set_in(input logic lu, br, mul, req, ack, clr, rst);
    i_lu = lu; i_br = br; i_mul = mul; i_req = req; i_ack = ack; i_clr = clr; i_rst = rst;
    bus.load_use_i     = lu;
    bus.branch_taken_i = br;
    bus.ex_mul_i       = mul;
    bus.mem_req_i      = req;
    bus.mem_ack_i      = ack;
    bus.stat_clr_i     = clr;
    rst_i              = rst;
  endtask

  // {pc, ifid_w, flush, idex_w, idex_bub, exmem_w, exmem_bub, memwb_bub, mul_start, cnt, tmo}
  function automatic logic [13:0] observed();
    return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_write_o,
            bus.idex_bubble_o, bus.exmem_write_o, bus.exmem_bubble_o,
            bus.memwb_bubble_o, bus.mul_start_o, bus.stall_cnt_o, bus.mem_timeout_o};
  endfunction

  // Expected outputs from the priority rules: freeze > MUL > load-use > branch.
  function automatic logic [13:0] expected();
    logic frz, in_mul, start, mstall, lu, pcw, flush;
    if (i_rst) return {9'b110101000, CNT_W'(m_stall), m_tmo};
    frz    = i_req && !i_ack;
    in_mul = (m_mul_left > 0);
    start  = !frz && !in_mul && i_mul;
    mstall = !frz && ((m_mul_left > 1) || start);
    lu     = !frz && !in_mul && !i_mul && i_lu;
    pcw    = !(frz || mstall || lu);
    flush  = i_br && pcw && !in_mul;
    return {pcw, pcw, flush, !(frz || mstall), lu, !frz, mstall, frz, start,
            CNT_W'(m_stall), m_tmo};
  endfunction

  task automatic model_step();
    logic [13:0] e;
    logic frz;
    e   = expected();
    frz = i_req && !i_ack;
    if (i_rst) begin
      m_mul_left = 0; m_stall = 0; m_frz = 0; m_tmo = 1'b0;
    end else begin
      if (i_clr) m_stall = 0;
      else if (!e[13] && m_stall < CNT_MAX) m_stall++;
      if (frz) begin
        m_frz++;
        if (m_frz >= MEM_TIMEOUT) m_tmo = 1'b1;
      end else begin
        m_frz = 0;
      end
      if (!frz) begin
        if (m_mul_left > 0) m_mul_left--;
        else if (i_mul) m_mul_left = MUL_LAT - 1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1);
    advance();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_reset cyc %0d: got %b want %b", i, observed(), expected());
      end
      advance();
    end
    n_cmp++;
    if ({bus.stall_cnt_o, bus.mem_timeout_o} !== {CNT_W'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL reset_counters: got %0d/%b want 0/0", bus.stall_cnt_o, bus.mem_timeout_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(i == 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_load_use cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus.pc_write_o, bus.ifid_write_o, bus.idex_bubble_o} !== 3'b001) begin
          n_bad++;
          $display("FAIL load_use_ctrl: got %b want 001",
                   {bus.pc_write_o, bus.ifid_write_o, bus.idex_bubble_o});
        end
      end
      advance();
    end
    n_cmp++;
    if (bus.stall_cnt_o !== CNT_W'(1)) begin
      n_bad++;
      $display("FAIL load_use_cnt: got %0d want 1", bus.stall_cnt_o);
    end
  endtask

  task automatic test_mul();
    logic [3:0] pcw_seq, start_seq;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, i == 0, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_mul cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (i < 4) begin
        pcw_seq[i]   = bus.pc_write_o;
        start_seq[i] = bus.mul_start_o;
      end
      advance();
    end
    n_cmp++;
    if ({pcw_seq, start_seq, bus.stall_cnt_o} !== {4'b1000, 4'b0001, CNT_W'(3)}) begin
      n_bad++;
      $display("FAIL mul_sequence: got pc=%b start=%b cnt=%0d want pc=1000 start=0001 cnt=3",
               pcw_seq, start_seq, bus.stall_cnt_o);
    end
  endtask

  task automatic test_freeze_in_mul();
    int nbub;
    logic [1:0] tail;
    nbub = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      // cycle 0 starts the MUL, cycles 2..6 freeze, cycles 7..8 finish it
      set_in(0, 0, i == 0, (i >= 2 && i <= 6), 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_freeze_in_mul cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (bus.memwb_bubble_o === 1'b1) nbub++;
      if (i >= 2 && i <= 6) begin
        n_cmp++;
        if (dut.mul_cnt_q !== 2'd2) begin
          n_bad++;
          $display("FAIL freeze_mul_hold cyc %0d: got %0d want 2", i, dut.mul_cnt_q);
        end
      end
      if (i >= 7) tail[i-7] = bus.pc_write_o;
      advance();
    end
    n_cmp++;
    if ({nbub, tail} !== {32'd5, 2'b10}) begin
      n_bad++;
      $display("FAIL freeze_mul_finish: got bubbles=%0d tail=%b want 5/10", nbub, tail);
    end
  endtask

  task automatic test_branch_vs_load_use();
    logic [1:0] fl;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(i == 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_branch cyc %0d: got %b want %b", i, observed(), expected());
      end
      fl[i] = bus.ifid_flush_o;
      advance();
    end
    n_cmp++;
    if (fl !== 2'b10) begin
      n_bad++;
      $display("FAIL branch_flush_seq: got %b want 10", fl);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 66; i++) begin
      // 64 freeze cycles, then the ack arrives, then idle
      set_in(0, 0, 0, i <= 64, i == 64, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_timeout cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (i == 63 || i == 64 || i == 65) begin
        n_cmp++;
        if (bus.mem_timeout_o !== (i != 63)) begin
          n_bad++;
          $display("FAIL timeout_flag cyc %0d: got %b want %b", i, bus.mem_timeout_o, i != 63);
        end
      end
      advance();
    end
    do_reset();
    n_cmp++;
    if (bus.mem_timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_reset: got %b want 0", bus.mem_timeout_o);
    end
  endtask

  task automatic test_saturation_and_abort();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_saturation cyc %0d: got %b want %b", i, observed(), expected());
      end
      advance();
    end
    n_cmp++;
    if (bus.stall_cnt_o !== CNT_W'(15)) begin
      n_bad++;
      $display("FAIL stall_cnt_sat: got %0d want 15", bus.stall_cnt_o);
    end
    set_in(1, 0, 0, 0, 0, 1, 0);
    advance();
    n_cmp++;
    if (bus.stall_cnt_o !== CNT_W'(0)) begin
      n_bad++;
      $display("FAIL stat_clr_priority: got %0d want 0", bus.stall_cnt_o);
    end
    // MUL start, one busy cycle, reset mid-MUL, then idle
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, i == 0, 0, 0, 0, i == 2);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_abort cyc %0d: got %b want %b", i, observed(), expected());
      end
      if (i >= 2) begin
        n_cmp++;
        if (observed() !== {9'b110101000, bus.stall_cnt_o, bus.mem_timeout_o}) begin
          n_bad++;
          $display("FAIL mul_abort_default cyc %0d: got %b want 110101000", i, observed());
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
             $urandom_range(9) < 3, $urandom_range(1) == 0, $urandom_range(31) == 0,
             $urandom_range(99) == 0);
      @(negedge clk);
      n_cmp++;
      if (observed() !== expected()) begin
        n_bad++;
        $display("FAIL test_random cyc %0d: got %b want %b", i, observed(), expected());
      end
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_mul_left = 0; m_stall = 0; m_frz = 0; m_tmo = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_mul();
    test_freeze_in_mul();
    test_branch_vs_load_use();
    test_timeout();
    test_saturation_and_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
